adder_datapath: RTL and testbench
=================================

Name: adder_datapath

Overview:
- Responder side of the adder control interface. Accepts load strobes, the operand-select (asel/bsel) and output_enable from the adder sequencing controller.
- Holds four operand registers and one accumulator, and produces the four-operand sum.
- Runs a protocol-tracking FSM so that only a legal control sequence updates the accumulator. Illegal sequences raise seq_err.
- Sits between the operand source and the result consumer.

Parameters:
- W, 8, operand width in bits. Sum width is W+2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_in, b_in, c_in, d_in  in  W each  operand data.
- aload, bload, cload, dload  in  1 each  operand register load strobes.
- asel  in  1  adder X input: 1 = A register, 0 = accumulator.
- bsel  in  2  adder Y input: 00 = B, 01 = C, 10 = D, 11 = illegal.
- output_enable  in  1  publish the accumulator to sum.
- sum  out  W+2  registered result.
- sum_valid  out  1  single-cycle pulse when sum updates.
- busy  out  1  high in any state other than IDLE.
- seq_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async): A, B, C, D, acc, sum = 0; sum_valid = 0; seq_err = 0; FSM = IDLE; busy = 0.
- Operand registers: each xload high at a clk edge captures x_in, in every state, independent of the FSM.
- Adder: X is zero-extended to W+2 bits. The add is W+2 wide and can never overflow (max 4*(2^W - 1)).
- FSM states: IDLE, LOAD, ADD_C, ADD_D, WAIT_OE.
- IDLE:
  - All four loads high -> LOAD.
  - Partial loads: registers capture, FSM stays in IDLE, no error.
  - asel, bsel and output_enable are ignored.
- LOAD:
  - All loads high -> stay in LOAD (operands recapture).
  - All loads low, asel=1, bsel=00 -> acc <= A+B, go to ADD_C.
  - Anything else -> seq_err=1, go to IDLE.
- ADD_C: loads low, asel=0, bsel=01 -> acc <= acc+C, go to ADD_D. Else seq_err=1, go to IDLE.
- ADD_D: loads low, asel=0, bsel=10 -> acc <= acc+D, go to WAIT_OE. Else seq_err=1, go to IDLE.
- WAIT_OE:
  - output_enable=1 -> sum <= acc, sum_valid=1 for exactly one cycle, go to IDLE.
  - asel/bsel holding their last values is legal and ignored.
  - All four loads high -> seq_err=1, operands recapture, go to LOAD.
  - Otherwise stay in WAIT_OE indefinitely.
- Outside WAIT_OE, output_enable is ignored: no sum update, no error.
- Validation timing: the FSM checks asel/bsel in the cycle they are presented. acc updates at the same edge as the state advance.
- Latency: sum_valid asserts on the edge after the output_enable sample. The minimum sequence is load-to-sum_valid in 5 edges.
- seq_err clears only on rst. An error does not block later legal sequences.
- Reset mid-operation: immediate return to reset values. Any partial accumulation is discarded. sum keeps 0 until the next completed sequence.
- Simultaneous output_enable with all loads high in WAIT_OE: the result is published (sum, sum_valid) and the FSM goes to LOAD with the new operands. No error.

Decomposition:
- Shared package holds:
  - state encodings (3-bit, IDLE=000 through WAIT_OE=100);
  - bsel codes BSEL_B=2'b00, BSEL_C=2'b01, BSEL_D=2'b10;
  - SUMW = W+2.
- One natural sub-module: adder_seq_checker. It holds the FSM plus the legality decode and outputs acc_en, sum_en, err_set and busy. The operand registers, adder mux and accumulator stay in the top module.

Test Plan:
- W=8. Present a=10, b=20, c=30, d=40 with the legal sequence (load, A+B, +C, +D, output_enable) -> sum=100, sum_valid high exactly 1 cycle, seq_err=0, busy low after.
- All operands 255 -> sum=1020 (10'h3FC), no truncation.
- Legal load, then asel=0, bsel=10 in the ADD_C slot -> seq_err=1, FSM in IDLE, sum unchanged (0). A following legal sequence of 1, 2, 3, 4 -> sum=10, seq_err still 1.
- Assert rst during ADD_D (acc=60) -> sum=0, busy=0 immediately. A fresh sequence of 5, 5, 5, 5 -> sum=20.
- Hold WAIT_OE for 10 cycles, then output_enable -> sum publishes once, 1-cycle sum_valid. Pulse output_enable in IDLE -> no sum_valid, no error.
- Back-to-back: output_enable together with new loads of 1, 1, 1, 1 -> first sum published, next sequence completes with sum=4, seq_err=0.

Source files
------------

// File: rtl/adder_datapath_pkg.sv
// Shared definitions for the four-operand adder datapath and its sequence checker.
package adder_datapath_pkg;

  localparam int W_DEFAULT = 8;
  localparam int SUMW      = W_DEFAULT + 2;

  // Protocol-tracking states; encodings are fixed so they can be probed on a bus.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_LOAD    = 3'b001,
    ST_ADD_C   = 3'b010,
    ST_ADD_D   = 3'b011,
    ST_WAIT_OE = 3'b100
  } state_t;

  // Adder Y-input select codes; 2'b11 is not a legal code.
  localparam logic [1:0] BSEL_B = 2'b00;
  localparam logic [1:0] BSEL_C = 2'b01;
  localparam logic [1:0] BSEL_D = 2'b10;

endpackage

// File: rtl/adder_seq_checker.sv
// Tracks the controller's load/select/output_enable sequence and decides which
// control actions are legal this cycle.
module adder_seq_checker
  import adder_datapath_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       aload,
  input  logic       bload,
  input  logic       cload,
  input  logic       dload,
  input  logic       asel,
  input  logic [1:0] bsel,
  input  logic       output_enable,
  output logic       acc_en,
  output logic       sum_en,
  output logic       err_set,
  output logic       busy
);

  state_t state;
  state_t state_next;
  logic   all_load;
  logic   no_load;

  assign all_load = aload & bload & cload & dload;
  assign no_load  = ~(aload | bload | cload | dload);

  // Legality decode: next state plus the same-edge accumulator/result/error strobes.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_next = state;
    acc_en     = 1'b0;
    sum_en     = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (all_load) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (all_load) begin
          state_next = ST_LOAD;
        end else if (no_load && asel && bsel == BSEL_B) begin
          acc_en     = 1'b1;
          state_next = ST_ADD_C;
        end else begin
          err_set    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_ADD_C: begin
        if (no_load && !asel && bsel == BSEL_C) begin
          acc_en     = 1'b1;
          state_next = ST_ADD_D;
        end else begin
          err_set    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_ADD_D: begin
        if (no_load && !asel && bsel == BSEL_D) begin
          acc_en     = 1'b1;
          state_next = ST_WAIT_OE;
        end else begin
          err_set    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_OE: begin
        // Publishing together with a fresh load is a legal back-to-back handoff.
        if (output_enable) begin
          sum_en     = 1'b1;
          state_next = all_load ? ST_LOAD : ST_IDLE;
        end else if (all_load) begin
          err_set    = 1'b1;
          state_next = ST_LOAD;
        end
      end
      default: begin
        err_set    = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register with busy registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
    end
  end

endmodule

// File: rtl/adder_datapath.sv
// Four-operand adder datapath: operand registers, adder input mux, accumulator
// and published result, sequenced by adder_seq_checker.
module adder_datapath
  import adder_datapath_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic [W-1:0] c_in,
  input  logic [W-1:0] d_in,
  input  logic         aload,
  input  logic         bload,
  input  logic         cload,
  input  logic         dload,
  input  logic         asel,
  input  logic [1:0]   bsel,
  input  logic         output_enable,
  output logic [W+1:0] sum,
  output logic         sum_valid,
  output logic         busy,
  output logic         seq_err
);

  localparam int SW = W + 2;

  logic [W-1:0]  a_q, b_q, c_q, d_q;
  logic [SW-1:0] acc;
  logic [SW-1:0] add_x, add_y, add_out;
  logic          acc_en, sum_en, err_set;

  adder_seq_checker u_checker (
    .clk           (clk),
    .rst           (rst),
    .aload         (aload),
    .bload         (bload),
    .cload         (cload),
    .dload         (dload),
    .asel          (asel),
    .bsel          (bsel),
    .output_enable (output_enable),
    .acc_en        (acc_en),
    .sum_en        (sum_en),
    .err_set       (err_set),
    .busy          (busy)
  );

  // Operand registers load on their own strobe regardless of protocol state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
    end else begin
      if (aload) a_q <= a_in;
      if (bload) b_q <= b_in;
      if (cload) c_q <= c_in;
      if (dload) d_q <= d_in;
    end
  end

  // Adder input mux; operands are zero-extended so the W+2 sum cannot overflow.
  always_comb begin
    add_x = asel ? {2'b00, a_q} : acc;
    unique case (bsel)
      BSEL_B:  add_y = {2'b00, b_q};
      BSEL_C:  add_y = {2'b00, c_q};
      BSEL_D:  add_y = {2'b00, d_q};
      default: add_y = '0;
    endcase
    add_out = add_x + add_y;
  end

  // Accumulator, published result, valid pulse and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      if (acc_en) acc <= add_out;
      if (sum_en) sum <= acc;
      sum_valid <= sum_en;
      seq_err   <= seq_err | err_set;
    end
  end

endmodule

// File: tb/tb_adder_datapath.sv
// Directed self-checking bench for adder_datapath with hand-computed results.
module tb_adder_datapath;
  import adder_datapath_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a_in, b_in, c_in, d_in;
  logic         aload, bload, cload, dload;
  logic         asel;
  logic [1:0]   bsel;
  logic         output_enable;
  logic [W+1:0] sum;
  logic         sum_valid;
  logic         busy;
  logic         seq_err;

  int checks = 0;
  int errors = 0;

  adder_datapath #(.W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .a_in          (a_in),
    .b_in          (b_in),
    .c_in          (c_in),
    .d_in          (d_in),
    .aload         (aload),
    .bload         (bload),
    .cload         (cload),
    .dload         (dload),
    .asel          (asel),
    .bsel          (bsel),
    .output_enable (output_enable),
    .sum           (sum),
    .sum_valid     (sum_valid),
    .busy          (busy),
    .seq_err       (seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_loads(input logic v);
    aload = v; bload = v; cload = v; dload = v;
  endtask

  task automatic start_load(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] d);
    a_in = a; b_in = b; c_in = c; d_in = d;
    set_loads(1'b1);
    tick();
    set_loads(1'b0);
  endtask

  task automatic step(input logic s_a, input logic [1:0] s_b);
    asel = s_a;
    bsel = s_b;
    tick();
  endtask

  // Load then run A+B, +C, +D, leaving the checker in WAIT_OE.
  task automatic to_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d);
    start_load(a, b, c, d);
    step(1'b1, BSEL_B);
    step(1'b0, BSEL_C);
    step(1'b0, BSEL_D);
  endtask

  // Pulse output_enable and check a single-cycle publish back to IDLE.
  task automatic publish(input string tag, input logic [31:0] expected);
    output_enable = 1'b1;
    tick();
    output_enable = 1'b0;
    check({tag, "_sum"}, sum, expected);
    check({tag, "_valid_hi"}, sum_valid, 1);
    tick();
    check({tag, "_valid_lo"}, sum_valid, 0);
    check({tag, "_sum_hold"}, sum, expected);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_in = '0; b_in = '0; c_in = '0; d_in = '0;
    set_loads(1'b0);
    asel = 1'b0;
    bsel = BSEL_B;
    output_enable = 1'b0;
    #12;
    check("rst_sum", sum, 0);
    check("rst_valid", sum_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", seq_err, 0);
    rst = 1'b0;
    tick();

    // Partial loads in IDLE: registers capture, no state change, no error.
    aload = 1'b1;
    a_in  = 8'd99;
    tick();
    aload = 1'b0;
    check("partial_busy", busy, 0);
    check("partial_err", seq_err, 0);

    // Basic legal sequence 10+20+30+40.
    start_load(8'd10, 8'd20, 8'd30, 8'd40);
    check("seq1_load_busy", busy, 1);
    step(1'b1, BSEL_B);
    step(1'b0, BSEL_C);
    step(1'b0, BSEL_D);
    check("seq1_wait_busy", busy, 1);
    check("seq1_wait_novalid", sum_valid, 0);
    check("seq1_wait_sum", sum, 0);
    publish("seq1", 100);
    check("seq1_err", seq_err, 0);

    // All operands at maximum: 4*255 = 1020, no truncation.
    to_wait(8'd255, 8'd255, 8'd255, 8'd255);
    publish("max", 10'h3FC);

    // Wrong select in the ADD_C slot, then a legal sequence with error sticky.
    pulse_reset();
    tick();
    start_load(8'd7, 8'd7, 8'd7, 8'd7);
    step(1'b1, BSEL_B);
    step(1'b0, BSEL_D);
    check("bad_err", seq_err, 1);
    check("bad_idle", busy, 0);
    check("bad_sum", sum, 0);
    to_wait(8'd1, 8'd2, 8'd3, 8'd4);
    publish("after_err", 10);
    check("after_err_sticky", seq_err, 1);

    // Reset while in ADD_D with acc=60 discards everything.
    start_load(8'd10, 8'd20, 8'd30, 8'd40);
    step(1'b1, BSEL_B);
    step(1'b0, BSEL_C);
    check("mid_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_sum", sum, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", seq_err, 0);
    #2;
    rst = 1'b0;
    tick();
    check("mid_rst_sum_hold", sum, 0);
    to_wait(8'd5, 8'd5, 8'd5, 8'd5);
    publish("fresh", 20);

    // Hold WAIT_OE for 10 cycles with selects held, then publish once.
    to_wait(8'd3, 8'd6, 8'd9, 8'd12);
    for (int i = 0; i < 10; i++) tick();
    check("hold_busy", busy, 1);
    check("hold_novalid", sum_valid, 0);
    check("hold_sum_old", sum, 20);
    check("hold_err", seq_err, 0);
    publish("hold", 30);

    // output_enable in IDLE is ignored.
    output_enable = 1'b1;
    tick();
    output_enable = 1'b0;
    check("idle_oe_valid", sum_valid, 0);
    check("idle_oe_err", seq_err, 0);
    check("idle_oe_sum", sum, 30);
    check("idle_oe_busy", busy, 0);

    // Back-to-back: publish together with a fresh all-load.
    to_wait(8'd10, 8'd20, 8'd30, 8'd40);
    a_in = 8'd1; b_in = 8'd1; c_in = 8'd1; d_in = 8'd1;
    set_loads(1'b1);
    output_enable = 1'b1;
    tick();
    set_loads(1'b0);
    output_enable = 1'b0;
    check("b2b_sum1", sum, 100);
    check("b2b_valid1", sum_valid, 1);
    check("b2b_load_busy", busy, 1);
    check("b2b_err", seq_err, 0);
    step(1'b1, BSEL_B);
    check("b2b_valid_lo", sum_valid, 0);
    step(1'b0, BSEL_C);
    step(1'b0, BSEL_D);
    publish("b2b2", 4);
    check("b2b_err_end", seq_err, 0);

    // Reload in WAIT_OE without output_enable flags an error but still restarts.
    to_wait(8'd9, 8'd9, 8'd9, 8'd9);
    start_load(8'd2, 8'd2, 8'd2, 8'd2);
    check("reload_err", seq_err, 1);
    check("reload_busy", busy, 1);
    check("reload_novalid", sum_valid, 0);
    step(1'b1, BSEL_B);
    step(1'b0, BSEL_C);
    step(1'b0, BSEL_D);
    publish("reload", 8);

    // Illegal bsel code in the LOAD slot.
    start_load(8'd1, 8'd1, 8'd1, 8'd1);
    step(1'b1, 2'b11);
    check("bsel11_idle", busy, 0);
    check("bsel11_sum", sum, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
